// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared FSM state and reset-cause encodings for reset_sequencer
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } seq_state_t;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_POR  = 2'b01;
    localparam logic [1:0] CAUSE_SW   = 2'b10;
    localparam logic [1:0] CAUSE_WDT  = 2'b11;

endpackage

// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - request/status bundle of reset_sequencer (RESET_SEQUENCER_WDT_EN adds wdt_kick_i)
interface reset_sequencer_if #(
    parameter int NUM_DOMAINS = 4
);

    logic                   sw_rst_req_i;
`ifdef RESET_SEQUENCER_WDT_EN
    logic                   wdt_kick_i;
`endif
    logic [NUM_DOMAINS-1:0] domain_rst_n_o;
    logic                   rst_done_o;
    logic [1:0]             rst_cause_o;

    // The sequencer side drives resets and status, the consumer side drives requests.
    modport master (
`ifdef RESET_SEQUENCER_WDT_EN
        input  wdt_kick_i,
`endif
        input  sw_rst_req_i,
        output domain_rst_n_o,
        output rst_done_o,
        output rst_cause_o
    );

    modport slave (
`ifdef RESET_SEQUENCER_WDT_EN
        output wdt_kick_i,
`endif
        output sw_rst_req_i,
        input  domain_rst_n_o,
        input  rst_done_o,
        input  rst_cause_o
    );

endinterface

// File: rtl/rst_sync_2ff.sv
// rtl/rst_sync_2ff.sv - two-flop reset deassertion synchroniser
module rst_sync_2ff (
    input  logic clk,
    input  logic asyncrst_n,
    output logic sync_o
);

    logic meta;

    // Clear immediately on reset, shift a one through two stages on release.
    always_ff @(posedge clk or negedge asyncrst_n) begin
        if (!asyncrst_n) begin
            meta   <= 1'b0;
            sync_o <= 1'b0;
        end else begin
            meta   <= 1'b1;
            sync_o <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - sequenced multi-domain reset release with SW reset and cause record; optional watchdog under RESET_SEQUENCER_WDT_EN
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS    = 4,
    parameter int STRETCH_CYCLES = 16,
    parameter int STEP_CYCLES    = 8,
    parameter int CNT_W          = 8
`ifdef RESET_SEQUENCER_WDT_EN
    ,
    parameter int WDT_TIMEOUT    = 1024
`endif
) (
    input  logic                clk,
    input  logic                asyncrst_n,
    reset_sequencer_if.master   bus
);

    localparam int KW = $clog2(NUM_DOMAINS + 1);

    logic                   sync;
    seq_state_t             state, state_nx;
    logic [CNT_W-1:0]       cnt, cnt_nx;
    logic [KW-1:0]          k, k_nx;
    logic [NUM_DOMAINS-1:0] dom, dom_nx;
    logic                   done, done_nx;
    logic [1:0]             cause, cause_nx;
    logic                   wdt_hit;

`ifdef RESET_SEQUENCER_WDT_EN
    localparam int WW = $clog2(WDT_TIMEOUT) + 1;
    logic [WW-1:0]          wdt, wdt_nx;
`endif

    rst_sync_2ff u_sync (
        .clk        (clk),
        .asyncrst_n (asyncrst_n),
        .sync_o     (sync)
    );

    // State and output registers; the board reset clears everything and records POR.
    always_ff @(posedge clk or negedge asyncrst_n) begin
        if (!asyncrst_n) begin
            state <= HOLD;
            cnt   <= '0;
            k     <= '0;
            dom   <= '0;
            done  <= 1'b0;
            cause <= CAUSE_POR;
`ifdef RESET_SEQUENCER_WDT_EN
            wdt   <= '0;
`endif
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            k     <= k_nx;
            dom   <= dom_nx;
            done  <= done_nx;
            cause <= cause_nx;
`ifdef RESET_SEQUENCER_WDT_EN
            wdt   <= wdt_nx;
`endif
        end
    end

    // Next-state logic: a reset request restarts HOLD from any state, otherwise stretch then release in order.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        k_nx     = k;
        dom_nx   = dom;
        done_nx  = done;
        cause_nx = cause;
        wdt_hit  = 1'b0;
`ifdef RESET_SEQUENCER_WDT_EN
        wdt_nx   = '0;
        wdt_hit  = (state == RUN) && (wdt == WW'(WDT_TIMEOUT - 1)) && !bus.wdt_kick_i;
        if ((state == RUN) && !bus.sw_rst_req_i && !wdt_hit)
            wdt_nx = bus.wdt_kick_i ? '0 : wdt + 1'b1;
`endif
        if (bus.sw_rst_req_i || wdt_hit) begin
            state_nx = HOLD;
            cnt_nx   = '0;
            k_nx     = '0;
            dom_nx   = '0;
            done_nx  = 1'b0;
            cause_nx = bus.sw_rst_req_i ? CAUSE_SW : CAUSE_WDT;
        end else begin
            case (state)
                HOLD: begin
                    if (sync) begin
                        if (cnt == CNT_W'(STRETCH_CYCLES - 1)) begin
                            dom_nx   = NUM_DOMAINS'(1);
                            cnt_nx   = '0;
                            k_nx     = KW'(1);
                            state_nx = RELEASE;
                        end else begin
                            cnt_nx = cnt + 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    if (k == KW'(NUM_DOMAINS)) begin
                        done_nx  = 1'b1;
                        cnt_nx   = '0;
                        state_nx = RUN;
                    end else if (cnt == CNT_W'(STEP_CYCLES - 1)) begin
                        dom_nx = dom | (NUM_DOMAINS'(1) << k);
                        k_nx   = k + 1'b1;
                        cnt_nx = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                RUN: begin
                end
                default: begin
                    state_nx = HOLD;
                    cnt_nx   = '0;
                    k_nx     = '0;
                    dom_nx   = '0;
                    done_nx  = 1'b0;
                end
            endcase
        end
    end

    assign bus.domain_rst_n_o = dom;
    assign bus.rst_done_o     = done;
    assign bus.rst_cause_o    = cause;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer (watchdog steps under RESET_SEQUENCER_WDT_EN)
module tb_reset_sequencer;
    import reset_seq_pkg::*;

    logic clk = 1'b0;
    logic rst1_n = 1'b1;
    logic rst2_n = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    reset_sequencer_if #(.NUM_DOMAINS(4)) bus1 ();
    reset_sequencer_if #(.NUM_DOMAINS(1)) bus2 ();

    reset_sequencer #(
        .NUM_DOMAINS    (4),
        .STRETCH_CYCLES (16),
        .STEP_CYCLES    (8),
        .CNT_W          (8)
`ifdef RESET_SEQUENCER_WDT_EN
        ,
        .WDT_TIMEOUT    (8)
`endif
    ) dut1 (
        .clk        (clk),
        .asyncrst_n (rst1_n),
        .bus        (bus1)
    );

    reset_sequencer #(
        .NUM_DOMAINS    (1),
        .STRETCH_CYCLES (1),
        .STEP_CYCLES    (1),
        .CNT_W          (2)
    ) dut2 (
        .clk        (clk),
        .asyncrst_n (rst2_n),
        .bus        (bus2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit i of a 4-domain sequence is released STEP (8) edges after bit i-1; done one edge after bit 3.
    function automatic logic [3:0] exp_dom(input int t, input int b0);
        logic [3:0] v;
        v = 4'h0;
        for (int i = 0; i < 4; i++)
            if (t >= b0 + 8 * i) v[i] = 1'b1;
        return v;
    endfunction

    task automatic seq_check(input int first, input int last, input int b0,
                             input logic [1:0] c, input string tag);
        for (int t = first; t <= last; t++) begin
            tick();
            chk($sformatf("%s_dom_t%0d", tag, t), 32'(bus1.domain_rst_n_o), 32'(exp_dom(t, b0)));
            chk($sformatf("%s_done_t%0d", tag, t), 32'(bus1.rst_done_o), 32'(t >= b0 + 25));
            chk($sformatf("%s_cause_t%0d", tag, t), 32'(bus1.rst_cause_o), 32'(c));
        end
    endtask

    task automatic sw_run(input int held, input string tag);
        @(negedge clk);
        bus1.sw_rst_req_i = 1'b1;
        for (int h = 0; h < held; h++) begin
            tick();
            chk($sformatf("%s_req_dom_%0d", tag, h), 32'(bus1.domain_rst_n_o), 32'h0);
            chk($sformatf("%s_req_done_%0d", tag, h), 32'(bus1.rst_done_o), 32'h0);
            chk($sformatf("%s_req_cause_%0d", tag, h), 32'(bus1.rst_cause_o), 32'(CAUSE_SW));
        end
        @(negedge clk);
        bus1.sw_rst_req_i = 1'b0;
        seq_check(1, 45, 16, CAUSE_SW, tag);
    endtask

    initial begin
        bus1.sw_rst_req_i = 1'b0;
        bus2.sw_rst_req_i = 1'b0;
`ifdef RESET_SEQUENCER_WDT_EN
        bus1.wdt_kick_i = 1'b1;
        bus2.wdt_kick_i = 1'b1;
`endif
        repeat (2) @(negedge clk);

        // POR: mid-cycle assertion clears outputs without a clock edge.
        #2;
        rst1_n = 1'b0;
        rst2_n = 1'b0;
        #1;
        chk("por_async_dom", 32'(bus1.domain_rst_n_o), 32'h0);
        chk("por_async_done", 32'(bus1.rst_done_o), 32'h0);
        chk("por_async_cause", 32'(bus1.rst_cause_o), 32'(CAUSE_POR));
        chk("c1_async_dom", 32'(bus2.domain_rst_n_o), 32'h0);
        @(negedge clk);
        rst1_n = 1'b1;
        seq_check(0, 45, 17, CAUSE_POR, "por");

        // SW pulse of one cycle, then held for five cycles.
        sw_run(1, "sw1");
        sw_run(5, "sw5");

        // Async reset after bit 1 is out, with a SW request present at the same edge.
        @(negedge clk);
        #2;
        rst1_n = 1'b0;
        #1;
        chk("rearm_cause", 32'(bus1.rst_cause_o), 32'(CAUSE_POR));
        @(negedge clk);
        rst1_n = 1'b1;
        seq_check(0, 27, 17, CAUSE_POR, "por2");
        @(negedge clk);
        #2;
        rst1_n = 1'b0;
        bus1.sw_rst_req_i = 1'b1;
        #1;
        chk("midrel_dom", 32'(bus1.domain_rst_n_o), 32'h0);
        chk("midrel_done", 32'(bus1.rst_done_o), 32'h0);
        chk("midrel_cause", 32'(bus1.rst_cause_o), 32'(CAUSE_POR));
        tick();
        chk("async_wins_cause", 32'(bus1.rst_cause_o), 32'(CAUSE_POR));
        chk("async_wins_dom", 32'(bus1.domain_rst_n_o), 32'h0);
        @(negedge clk);
        bus1.sw_rst_req_i = 1'b0;
        rst1_n = 1'b1;
        seq_check(0, 45, 17, CAUSE_POR, "por3");

        // Corner build: one domain, stretch 1, step 1 -> bit0 at E2, done at E3.
        @(negedge clk);
        rst2_n = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            tick();
            chk($sformatf("c1_dom_e%0d", e), 32'(bus2.domain_rst_n_o), 32'(e >= 2));
            chk($sformatf("c1_done_e%0d", e), 32'(bus2.rst_done_o), 32'(e >= 3));
            chk($sformatf("c1_cause_e%0d", e), 32'(bus2.rst_cause_o), 32'(CAUSE_POR));
        end

`ifdef RESET_SEQUENCER_WDT_EN
        // No kicks in RUN: reset on the 8th RUN edge with cause WDT.
        @(negedge clk);
        bus1.wdt_kick_i = 1'b0;
        for (int r = 1; r <= 7; r++) begin
            tick();
            chk($sformatf("wdt_wait_dom_%0d", r), 32'(bus1.domain_rst_n_o), 32'hf);
        end
        tick();
        chk("wdt_fire_dom", 32'(bus1.domain_rst_n_o), 32'h0);
        chk("wdt_fire_done", 32'(bus1.rst_done_o), 32'h0);
        chk("wdt_fire_cause", 32'(bus1.rst_cause_o), 32'(CAUSE_WDT));
        @(negedge clk);
        bus1.wdt_kick_i = 1'b1;
        seq_check(1, 45, 16, CAUSE_WDT, "wdt");
        // Kicking every 7 cycles keeps the count below the timeout.
        for (int i = 0; i < 63; i++) begin
            @(negedge clk);
            bus1.wdt_kick_i = (i % 7 == 0);
            tick();
            chk($sformatf("wdt_kick_dom_%0d", i), 32'(bus1.domain_rst_n_o), 32'hf);
            chk($sformatf("wdt_kick_cause_%0d", i), 32'(bus1.rst_cause_o), 32'(CAUSE_WDT));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Central reset source for a single clock domain.
- Takes the board/POR reset and releases NUM_DOMAINS downstream reset outputs one at a time, in index order, with a programmable gap between releases.
- Also generates synchronous software-requested resets with a guaranteed minimum pulse width, and records the cause of the last reset.
- Sits at the top of the clock/reset tree; its outputs feed the per-block resets.

Parameters:
- NUM_DOMAINS, 4: number of sequenced reset outputs; must be ≥1.
- STRETCH_CYCLES, 16: minimum hold of all outputs after the reset source goes away; must be ≥1.
- STEP_CYCLES, 8: cycles between consecutive domain releases; must be ≥1.
- CNT_W, 8: counter width; must satisfy 2^CNT_W > max(STRETCH_CYCLES, STEP_CYCLES).

Ports:
- clk  input  1  system clock.
- asyncrst_n  input  1  asynchronous, active-low reset.
- sw_rst_req_i  input  1  synchronous software reset request; level-sampled each edge.
- domain_rst_n_o  output  NUM_DOMAINS  per-domain active-low reset; bit 0 is released first.
- rst_done_o  output  1  high once every domain is released.
- rst_cause_o  output  2  cause of last reset: 01 = POR, 10 = SW, 11 = WDT (feature only), 00 = never driven.

Behaviour:
- Reset is asyncrst_n, asynchronous, active-low; clock is clk.
- asyncrst_n low, immediately with no clock needed:
  - domain_rst_n_o = 0, rst_done_o = 0, rst_cause_o = 01.
  - state = HOLD, counters = 0, internal 2-flop synchroniser = 00.
- Deassertion is synchronous. Define E0 as the first rising edge with asyncrst_n high:
  - Synchroniser output rises after E1.
  - HOLD counts edges E2 to E(1+STRETCH_CYCLES).
- FSM states: HOLD, RELEASE, RUN.
- HOLD:
  - All outputs held at 0.
  - Counter increments while the synchroniser output is 1.
  - At the count edge where cnt == STRETCH_CYCLES-1: set domain_rst_n_o[0] = 1, clear cnt, go to RELEASE with index k = 1.
- RELEASE:
  - Counts STEP_CYCLES per domain.
  - At each completed step, set domain_rst_n_o[k] = 1 and increment k.
  - After bit NUM_DOMAINS-1 is set, rst_done_o = 1 on the next edge and state goes to RUN.
  - With NUM_DOMAINS = 1, go straight from HOLD to the done edge.
- Timing with defaults:
  - Bit0 released at E17, bit1 at E25, bit2 at E33, bit3 at E41.
  - rst_done_o rises at E42.
- Released bits stay 1 until the next reset event. Bits are monotonic within one sequence.
- sw_rst_req_i sampled 1 at edge T, in any state:
  - At T: all domain_rst_n_o = 0, rst_done_o = 0, rst_cause_o = 10.
  - Go to HOLD with cnt = 0; the synchroniser is not involved.
  - domain 0 is released at T+STRETCH_CYCLES.
- Request held high: HOLD restarts every edge, so outputs stay asserted until one edge after the request drops.
- Request during HOLD or RELEASE: the sequence restarts from HOLD and every bit is reasserted at that edge.
- asyncrst_n low at any time: overrides everything asynchronously; cause = 01.
- Simultaneous async reset and SW request: async reset wins.
- No combinational path from any input to any output, except the asynchronous reset path.

Optional Feature:
RESET_SEQUENCER_WDT_EN
- Defined:
  - Adds input wdt_kick_i (1 bit) and parameter WDT_TIMEOUT (default 1024).
  - In RUN, a watchdog counter increments each cycle and clears on wdt_kick_i = 1.
  - On reaching WDT_TIMEOUT-1 without a kick, the next edge behaves exactly like a SW request, with rst_cause_o = 11.
  - The watchdog counter is cleared, and frozen, outside RUN.
  - A SW request and a timeout on the same edge give cause 10.
- Undefined:
  - No wdt_kick_i port and no watchdog logic.
  - Cause 11 is never produced.

Decomposition:
- Package reset_seq_pkg:
  - FSM state enum {HOLD, RELEASE, RUN}.
  - Cause localparams CAUSE_NONE = 2'b00, CAUSE_POR = 2'b01, CAUSE_SW = 2'b10, CAUSE_WDT = 2'b11.
- Sub-module rst_sync_2ff: 2-flop deassertion synchroniser.
  - Ports: clk, asyncrst_n, sync_o.
  - Asynchronous clear to 0; shifts in 1.
  - Instantiated once.

Test Plan:
1. POR, defaults: drop asyncrst_n mid-cycle, then release before E0 → outputs 0 instantly with no clock edge; bits released at E17/E25/E33/E41; rst_done_o at E42; cause 01.
2. SW reset: in RUN, hold sw_rst_req_i high for 1 cycle at edge T → all bits 0 and cause 10 at T; bit0 at T+16; rst_done_o at T+41.
3. SW reset held 5 cycles from T → bit0 released at T+4+16 = T+20.
4. Async reset mid-RELEASE: assert asyncrst_n low after bit1 is released → all outputs 0 asynchronously; the full POR sequence restarts with cause 01.
5. Corner parameters NUM_DOMAINS = 1, STRETCH_CYCLES = 1, STEP_CYCLES = 1 → bit0 at E2, rst_done_o at E3.
6. Watchdog (RESET_SEQUENCER_WDT_EN defined, WDT_TIMEOUT = 8): no kicks in RUN → reset at the 8th RUN edge with cause 11. Kicking every 7 cycles → no reset.
